// File: rtl/ieeedrv_rom_loader.sv
// ieeedrv_rom_loader: turns the 16-bit HPS ioctl download into ascending byte writes on the drive ROM port.
// Define IEEEDRV_ROM_CSUM_EN to add per-section 16-bit byte checksums; otherwise csum_4040/csum_8250 read 0.
module ieeedrv_rom_loader #(
    parameter logic [7:0] ROM_INDEX = 8'd2,
    parameter int         SECT_SIZE = 18432
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic        rom_wr,
    output logic        rom_sel,
    output logic [14:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [1:0]  loaded,
    output logic        done,
    output logic        proto_err,
    output logic [15:0] csum_4040,
    output logic [15:0] csum_8250
);
    localparam logic [16:0] SECT_END  = 17'(SECT_SIZE);
    localparam logic [16:0] FILE_END  = 17'(2 * SECT_SIZE);
    localparam logic [16:0] LAST_4040 = 17'(SECT_SIZE - 1);
    localparam logic [16:0] LAST_8250 = 17'(2 * SECT_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t      state_r;
    logic        act_s;
    logic        act_d_r;
    logic        act_rise_s;
    logic        act_fall_s;
    logic        accept_s;
    logic        going_idle_s;
    logic [16:0] lo_off_s;
    logic        out_of_range_s;
    logic        in_4040_s;
    logic [14:0] map_addr_s;
    logic [16:0] hi_off_r;
    logic [7:0]  hi_byte_r;
    logic        skip_r;
    logic        done_pend_r;

    assign act_s      = ioctl_download && (ioctl_index == ROM_INDEX);
    assign act_rise_s = act_s && !act_d_r;
    assign act_fall_s = !act_s && act_d_r;
    assign accept_s   = ioctl_wr && act_s;

    // Section decode of the incoming word's even byte offset
    always_comb begin
        lo_off_s       = ioctl_addr[16:0];
        out_of_range_s = (ioctl_addr[24:17] != 8'd0) || (lo_off_s >= FILE_END);
        if (lo_off_s < SECT_END) begin
            in_4040_s  = 1'b1;
            map_addr_s = lo_off_s[14:0];
        end else begin
            in_4040_s  = 1'b0;
            map_addr_s = 15'(lo_off_s - SECT_END);
        end
    end

    // Whether the FSM will be in IDLE after this edge (gates the done pulse)
    always_comb begin
        case (state_r)
            IDLE:    going_idle_s = !accept_s;
            WR_LO:   going_idle_s = 1'b0;
            WR_HI:   going_idle_s = 1'b1;
            default: going_idle_s = 1'b1;
        endcase
    end

    // Word-to-byte FSM with registered ROM port, handshake and status flags
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            act_d_r     <= 1'b0;
            ioctl_wait  <= 1'b0;
            rom_wr      <= 1'b0;
            rom_sel     <= 1'b0;
            rom_addr    <= 15'd0;
            rom_data    <= 8'd0;
            loaded      <= 2'b00;
            done        <= 1'b0;
            proto_err   <= 1'b0;
            hi_off_r    <= 17'd0;
            hi_byte_r   <= 8'd0;
            skip_r      <= 1'b0;
            done_pend_r <= 1'b0;
        end else begin
            act_d_r <= act_s;
            rom_wr  <= 1'b0;
            done    <= 1'b0;
            if (act_rise_s) begin
                loaded <= 2'b00;
            end
            // a download that ends mid-word reports done only once the word is fully written
            if (act_fall_s || done_pend_r) begin
                if (going_idle_s) begin
                    done        <= 1'b1;
                    done_pend_r <= 1'b0;
                end else begin
                    done_pend_r <= 1'b1;
                end
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r    <= WR_LO;
                        ioctl_wait <= 1'b1;
                        hi_byte_r  <= ioctl_dout[15:8];
                        hi_off_r   <= {lo_off_s[16:1], 1'b1};
                        skip_r     <= out_of_range_s;
                        if (!out_of_range_s) begin
                            rom_wr   <= 1'b1;
                            rom_sel  <= in_4040_s;
                            rom_addr <= map_addr_s;
                            rom_data <= ioctl_dout[7:0];
                        end
                    end
                end
                WR_LO: begin
                    if (ioctl_wr) begin
                        proto_err <= 1'b1;
                    end
                    state_r <= WR_HI;
                    if (!skip_r) begin
                        rom_wr   <= 1'b1;
                        rom_addr <= {rom_addr[14:1], 1'b1};
                        rom_data <= hi_byte_r;
                        if (hi_off_r == LAST_4040) begin
                            loaded[1] <= 1'b1;
                        end
                        if (hi_off_r == LAST_8250) begin
                            loaded[0] <= 1'b1;
                        end
                    end
                end
                WR_HI: begin
                    if (ioctl_wr) begin
                        proto_err <= 1'b1;
                    end
                    state_r    <= IDLE;
                    ioctl_wait <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    ioctl_wait <= 1'b0;
                end
            endcase
        end
    end

`ifdef IEEEDRV_ROM_CSUM_EN
    logic [15:0] csum_4040_r;
    logic [15:0] csum_8250_r;

    // Per-section wrap-around byte sums, updated the cycle after each write
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            csum_4040_r <= 16'd0;
            csum_8250_r <= 16'd0;
        end else if (act_rise_s) begin
            csum_4040_r <= 16'd0;
            csum_8250_r <= 16'd0;
        end else if (rom_wr) begin
            if (rom_sel) begin
                csum_4040_r <= csum_4040_r + {8'd0, rom_data};
            end else begin
                csum_8250_r <= csum_8250_r + {8'd0, rom_data};
            end
        end
    end

    assign csum_4040 = csum_4040_r;
    assign csum_8250 = csum_8250_r;
`else
    assign csum_4040 = 16'd0;
    assign csum_8250 = 16'd0;
`endif

endmodule

// File: tb/tb_ieeedrv_rom_loader.sv
// Self-checking bench for ieeedrv_rom_loader: directed words, scoreboard queue of expected ROM byte writes.
module tb_ieeedrv_rom_loader;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [15:0] ioctl_dout;
    logic        ioctl_wait;
    logic        rom_wr;
    logic        rom_sel;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data;
    logic [1:0]  loaded;
    logic        done;
    logic        proto_err;
    logic [15:0] csum_4040;
    logic [15:0] csum_8250;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [23:0] exp_q[$];

    ieeedrv_rom_loader dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .rom_wr(rom_wr), .rom_sel(rom_sel),
        .rom_addr(rom_addr), .rom_data(rom_data), .loaded(loaded),
        .done(done), .proto_err(proto_err),
        .csum_4040(csum_4040), .csum_8250(csum_8250)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    // Scoreboard monitor: every rom_wr byte must match the oldest expected write
    always @(negedge clk_sys) begin
        if (done === 1'b1) done_cnt++;
        if (rom_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr actual=sel%0d addr 0x%0h data 0x%0h required=no write",
                         rom_sel, rom_addr, rom_data);
            end else begin
                check("rom_write", {8'd0, rom_sel, rom_addr, rom_data}, {8'd0, exp_q.pop_front()});
            end
        end
    end

    // One word strobe; optionally checks wait/rom_wr in cycles 1..3 after the strobe
    task automatic send_word(input logic [24:0] a, input logic [15:0] d, input logic wr_exp,
                             input logic sel, input logic [14:0] ra, input logic chk);
        @(posedge clk_sys); #1;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (wr_exp) begin
            exp_q.push_back({sel, ra, d[7:0]});
            exp_q.push_back({sel, ra | 15'd1, d[15:8]});
        end
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        if (chk) begin
            @(negedge clk_sys);
            check("wait_c1", {31'd0, ioctl_wait}, 32'd1);
            check("wr_c1", {31'd0, rom_wr}, {31'd0, wr_exp});
            @(negedge clk_sys);
            check("wait_c2", {31'd0, ioctl_wait}, 32'd1);
            check("wr_c2", {31'd0, rom_wr}, {31'd0, wr_exp});
            @(negedge clk_sys);
            check("wait_c3", {31'd0, ioctl_wait}, 32'd0);
            check("wr_c3", {31'd0, rom_wr}, 32'd0);
        end else begin
            @(posedge clk_sys); #1;
        end
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr = 1'b0;
        ioctl_addr = 25'd0;
        ioctl_dout = 16'd0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_outputs", {rom_wr, ioctl_wait, done, proto_err, loaded, rom_sel},  32'd0);
        check("rst_rom_port", {9'd0, rom_addr, rom_data}, 32'd0);
        check("rst_csum", {csum_4040, csum_8250}, 32'd0);
        reset = 1'b0;

        // Basic mapping in both sections, top of 4040 section sets loaded[1]
        @(posedge clk_sys); #1;
        ioctl_index = 8'd2;
        ioctl_download = 1'b1;
        send_word(25'h00000, 16'h34A9, 1'b1, 1'b1, 15'h0000, 1'b1);
        send_word(25'h04800, 16'hBEEF, 1'b1, 1'b0, 15'h0000, 1'b1);
        send_word(25'h047FE, 16'h1122, 1'b1, 1'b1, 15'h47FE, 1'b1);
        check("loaded_4040", {30'd0, loaded}, 32'd2);
        // Beyond the file: no write, same handshake, ROM port holds
        send_word(25'h09000, 16'h5555, 1'b0, 1'b0, 15'h0000, 1'b1);
        check("hold_after_skip", {8'd0, rom_sel, rom_addr, rom_data}, 32'h00C7FF11);

        // Download end: done one cycle after act falls
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("done_early", {31'd0, done}, 32'd0);
        @(negedge clk_sys);
        check("done_pulse", {31'd0, done}, 32'd1);
        @(negedge clk_sys);
        check("done_once", {31'd0, done}, 32'd0);

        // Non-matching index: ignored entirely
        @(posedge clk_sys); #1;
        d0 = done_cnt;
        ioctl_index = 8'd3;
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_addr = 25'h00006;
        ioctl_dout = 16'h7777;
        ioctl_wr = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        check("idx3_wait", {31'd0, ioctl_wait}, 32'd0);
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        check("idx3_no_done", 32'(done_cnt - d0), 32'd0);
        check("idx3_loaded_kept", {30'd0, loaded}, 32'd2);

        // New matching download clears loaded; write while busy is dropped
        ioctl_index = 8'd2;
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        check("loaded_cleared", {30'd0, loaded}, 32'd0);
        check("proto_clean", {31'd0, proto_err}, 32'd0);
        ioctl_addr = 25'h00002;
        ioctl_dout = 16'h5678;
        ioctl_wr = 1'b1;
        exp_q.push_back({1'b1, 15'h0002, 8'h78});
        exp_q.push_back({1'b1, 15'h0003, 8'h56});
        @(posedge clk_sys); #1;
        ioctl_addr = 25'h00004;
        ioctl_dout = 16'hAAAA;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        check("proto_err_set", {31'd0, proto_err}, 32'd1);
        check("proto_wait_c2", {31'd0, ioctl_wait}, 32'd1);
        @(negedge clk_sys);
        check("proto_wait_c3", {31'd0, ioctl_wait}, 32'd0);

        // Download drops in cycle 1: high byte still written, done in cycle 3
        @(posedge clk_sys); #1;
        ioctl_addr = 25'h04802;
        ioctl_dout = 16'h9A9B;
        ioctl_wr = 1'b1;
        exp_q.push_back({1'b0, 15'h0002, 8'h9B});
        exp_q.push_back({1'b0, 15'h0003, 8'h9A});
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        check("drop_done_c1", {31'd0, done}, 32'd0);
        @(negedge clk_sys);
        check("drop_done_c2", {31'd0, done}, 32'd0);
        check("drop_hi_wr", {31'd0, rom_wr}, 32'd1);
        @(negedge clk_sys);
        check("drop_done_c3", {31'd0, done}, 32'd1);

        // Full two-section file of 0x01 bytes
        @(posedge clk_sys); #1;
        ioctl_download = 1'b1;
        for (int b = 0; b < 36864; b += 2) begin
            send_word(25'(b), 16'h0101, 1'b1, (b < 18432),
                      (b < 18432) ? 15'(b) : 15'(b - 18432), 1'b0);
        end
        @(posedge clk_sys); #1;
        check("full_loaded", {30'd0, loaded}, 32'd3);
`ifdef IEEEDRV_ROM_CSUM_EN
        check("csum_4040", {16'd0, csum_4040}, 32'h4800);
        check("csum_8250", {16'd0, csum_8250}, 32'h4800);
`else
        check("csum_4040_off", {16'd0, csum_4040}, 32'd0);
        check("csum_8250_off", {16'd0, csum_8250}, 32'd0);
`endif
        d0 = done_cnt;
        ioctl_download = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        check("full_one_done", 32'(done_cnt - d0), 32'd1);
        check("loaded_sticky", {30'd0, loaded}, 32'd3);

        // Reset asserted while the low byte is on the port
        ioctl_download = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_addr = 25'h00010;
        ioctl_dout = 16'hC3C4;
        ioctl_wr = 1'b1;
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
        check("pre_rst_wr", {31'd0, rom_wr}, 32'd1);
        check("pre_rst_proto", {31'd0, proto_err}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("rst_async", {28'd0, rom_wr, ioctl_wait, proto_err, done}, 32'd0);
        check("rst_async_loaded", {30'd0, loaded}, 32'd0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        check("rst_held_wr", {31'd0, rom_wr}, 32'd0);
        reset = 1'b0;
        send_word(25'h00020, 16'hD1D2, 1'b1, 1'b1, 15'h0020, 1'b1);

        repeat (3) @(posedge clk_sys);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
